// File: rtl/pattern_pkg.sv
// Constants shared by the serial pattern detector and the match LED controller.
package pattern_pkg;

    localparam int unsigned HOLD_CYCLES_DEF = 100_000_000;
    localparam int unsigned CNT_W_DEF       = 8;

    localparam int unsigned DET_PAT_LEN = 7;
    localparam logic [DET_PAT_LEN-1:0] DET_PATTERN = 7'b1010111;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StHold = ST_HOLD
    } led_state_e;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter for the LED hold time; zero flags an expired hold.
module hold_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/match_led_ctrl.sv
// Registers the detector match pulse, counts match events and holds an LED per event.
// Define MATCH_CNT_SAT_EN to make match_cnt saturate instead of wrapping.
module match_led_ctrl
    import pattern_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match_in,
    input  logic             clear,
    output logic             led,
    output logic [CNT_W-1:0] match_cnt,
    output logic             seen
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic match_q, match_d;
    logic match_evt;

    led_state_e       state_q, state_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             seen_q, seen_d;

    logic tmr_load, tmr_dec, tmr_clear, tmr_zero;

    // Two flops isolate the possibly combinational match_in from everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q <= 1'b0;
            match_d <= 1'b0;
        end else begin
            match_q <= match_in;
            match_d <= match_q;
        end
    end

    assign match_evt = match_q & ~match_d;

`ifdef MATCH_CNT_SAT_EN
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`else
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    hold_timer #(
        .W (HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (HOLD_RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_clear = 1'b0;

        if (clear) begin
            // A same-cycle event is dropped entirely.
            state_d   = StIdle;
            led_d     = 1'b0;
            cnt_d     = '0;
            seen_d    = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            if (match_evt) begin
                cnt_d  = cnt_inc;
                seen_d = 1'b1;
            end
            case (state_q)
                StIdle: begin
                    led_d = 1'b0;
                    if (match_evt) begin
                        state_d  = StHold;
                        led_d    = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
                StHold: begin
                    led_d = 1'b1;
                    if (match_evt) begin
                        tmr_load = 1'b1;
                    end else if (tmr_zero) begin
                        state_d = StIdle;
                        led_d   = 1'b0;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    led_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            led_q   <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    assign led       = led_q;
    assign match_cnt = cnt_q;
    assign seen      = seen_q;

endmodule

// File: doc/match_led_ctrl.md
Name: match_led_ctrl

Overview:
- Downstream consumer of the serial pattern detector's one-cycle Mealy match pulse.
- Registers the match pulse to remove combinational glitches, then counts match events.
- Lights an LED for a programmable hold time and retriggers the hold on every new match.
- Keeps a sticky "seen" flag; all outputs are registered and drive board LEDs directly.

Parameters:
- HOLD_CYCLES, 100_000_000, LED on-time in clk cycles per event (1 s at 100 MHz); legal range ≥ 1.
- CNT_W, 8, width of match event counter.
- HOLD_W, $clog2(HOLD_CYCLES)+1 (localparam, derived), width of hold timer.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- match_in  input  1  match pulse from pattern detector; may be combinational.
- clear  input  1  synchronous clear of count, seen flag and LED.
- led  output  1  high while hold is active.
- match_cnt  output  CNT_W  number of match events since reset/clear.
- seen  output  1  sticky; set on first event, cleared only by reset/clear.

Behaviour:
- Reset (reset=0, asynchronous): led=0, match_cnt=0, seen=0, state=IDLE, timer=0, input pipeline flops=0. All take effect immediately, including mid-hold.
- Input stage: match_q <= match_in; match_d <= match_q.
  - event = match_q & ~match_d, so each rising edge of match_in counts exactly once.
  - A match_in that stays high for several cycles is one event.
- Latency:
  - Let E0 be the clk edge that first samples match_in=1.
  - led, match_cnt and seen update at edge E0+1 and are visible one cycle after E0.
- FSM, two states:
  - IDLE: led=0. On event: go to HOLD, timer <= HOLD_CYCLES-1, led <= 1.
  - HOLD: led=1. On event: timer reloads to HOLD_CYCLES-1 (retrigger) and state stays HOLD. Else if timer==0: go to IDLE, led <= 0. Else timer decrements.
  - Illegal or unused encoding goes to IDLE.
- LED timing:
  - A single isolated event gives exactly HOLD_CYCLES consecutive cycles of led=1.
  - A retrigger k cycles into the hold extends led to k + HOLD_CYCLES cycles total.
- Counter:
  - match_cnt increments by 1 per event, in both IDLE and HOLD.
  - Without the optional feature, it wraps from 2^CNT_W-1 to 0.
- seen: set on the first event and held thereafter.
- clear (synchronous): match_cnt=0, seen=0, led=0, state=IDLE, timer=0.
  - clear has priority over a same-cycle event; that event is dropped (not counted, no hold).
- Only the pipeline flops sample match_in; match_in has no other path to any output.

Optional Feature:
- Macro: MATCH_CNT_SAT_EN.
- Defined: match_cnt saturates at 2^CNT_W-1. Further events still retrigger led and keep seen set but do not change the count.
- Undefined: match_cnt wraps modulo 2^CNT_W.

Decomposition:
- Shared package pattern_pkg:
  - state encoding localparams ST_IDLE=1'b0 and ST_HOLD=1'b1.
  - default HOLD_CYCLES and CNT_W constants.
  - detector-related constants (pattern length 7, pattern 7'b1010111), so detector and this block share one source.
- One natural sub-module: hold_timer.
  - Loadable down-counter with inputs load and load_val, and output zero.
  - Instantiated once; the FSM and counter stay in match_led_ctrl.

Test Plan (sim params HOLD_CYCLES=4, CNT_W=3):
- Hold reset=0 for 3 cycles with match_in toggling, then release -> led=0, match_cnt=0, seen=0 throughout reset and after release with match_in=0.
- Single 1-cycle match_in pulse sampled at edge E0 -> led=1 for exactly 4 cycles starting one cycle after E0; match_cnt=1; seen=1.
- Pulse, then second pulse 2 cycles after led rises -> led stays high continuously, 6 cycles total; match_cnt=2.
- match_in held high 5 cycles -> match_cnt increments once (=1); led high 4 cycles from the first event.
- 9 isolated pulses spaced 6 cycles apart:
  - macro undefined -> match_cnt sequence ends at 1 (wrapped);
  - MATCH_CNT_SAT_EN defined -> match_cnt ends at 7;
  - led pulses 9 times in both builds.
- Clear and mid-hold reset:
  - clear asserted in the same cycle event would fire -> match_cnt=0, seen=0, led stays 0.
  - Separately, reset=0 two cycles into a hold -> led=0 immediately (before the next edge), state IDLE after release.
